rename_stage: RTL and testbench

- Consumer end of the decode_data valid/ready stream driven by the front-end decode skid buffer.
- Single-wide register renaming: reads the RAT for sources, allocates a physical destination from a circular free list, updates the RAT, and emits a registered rename_data packet toward dispatch.
- Freed physical registers return from commit through a push port.

---
 rtl/rename_stage_pkg.sv | 37 +++
 rtl/rename_stage_free_list.sv | 62 ++++++
 rtl/rename_stage.sv | 110 +++++++++++
 tb/tb_rename_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rename_stage_pkg.sv
// Shared types and sizing for the rename stage and its free list.
package rename_stage_pkg;

  localparam int ARCH_REGS = 32;
  localparam int PHYS_REGS = 128;
  localparam int PREG_W    = $clog2(PHYS_REGS);
  localparam int AREG_W    = $clog2(ARCH_REGS);
  localparam int FL_DEPTH  = PHYS_REGS - ARCH_REGS;
  localparam int FL_PTR_W  = $clog2(FL_DEPTH);
  localparam int FL_CNT_W  = $clog2(FL_DEPTH + 1);

  typedef struct packed {
    logic [31:0]       pc;
    logic [AREG_W-1:0] rs1;
    logic [AREG_W-1:0] rs2;
    logic [AREG_W-1:0] rd;
    logic              reg_write;
  } decode_data_t;

  typedef struct packed {
    logic [31:0]       pc;
    logic [AREG_W-1:0] rs1;
    logic [AREG_W-1:0] rs2;
    logic [AREG_W-1:0] rd;
    logic              reg_write;
    logic [PREG_W-1:0] prs1;
    logic [PREG_W-1:0] prs2;
    logic [PREG_W-1:0] prd;
    logic [PREG_W-1:0] old_prd;
  } rename_data_t;

  // Circular pointer increment; the depth is not a power of two.
  function automatic logic [FL_PTR_W-1:0] fl_ptr_inc(input logic [FL_PTR_W-1:0] ptr);
    return (ptr == FL_PTR_W'(FL_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

endpackage

// File: rtl/rename_stage_free_list.sv
// Circular free list of physical tags; comes out of reset holding
// ARCH_REGS..PHYS_REGS-1 in ascending order.
module rename_stage_free_list
  import rename_stage_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                pop,
  input  logic                push,
  input  logic [PREG_W-1:0]   push_preg,
  output logic [PREG_W-1:0]   head_preg,
  output logic [FL_CNT_W-1:0] count
);

  logic [PREG_W-1:0]   entry_reg [FL_DEPTH];
  logic [FL_PTR_W-1:0] head_reg;
  logic [FL_PTR_W-1:0] tail_reg;
  logic [FL_CNT_W-1:0] count_reg;
  logic                pop_en;
  logic                push_en;

  assign pop_en  = pop && (count_reg != '0);
  // A push into a full list has nowhere to go and is dropped.
  assign push_en = push && (count_reg != FL_CNT_W'(FL_DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        entry_reg[i] <= PREG_W'(ARCH_REGS + i);
      end
    end else if (push_en) begin
      entry_reg[tail_reg] <= push_preg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= FL_CNT_W'(FL_DEPTH);
    end else begin
      if (pop_en) begin
        head_reg <= fl_ptr_inc(head_reg);
      end
      if (push_en) begin
        tail_reg <= fl_ptr_inc(tail_reg);
      end
      if (pop_en && !push_en) begin
        count_reg <= count_reg - 1'b1;
      end else if (push_en && !pop_en) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign head_preg = entry_reg[head_reg];
  assign count     = count_reg;

  push_while_full: assert property (@(posedge clk) disable iff (reset)
    !(push && count_reg == FL_CNT_W'(FL_DEPTH)));

endmodule

// File: rtl/rename_stage.sv
// Single-wide register rename: RAT lookup, free-list allocation, registered output.
// Optional RENAME_STALL_CNT_EN adds a saturating free-list-empty stall counter.
module rename_stage
  import rename_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_out,
  input  decode_data_t      data_in,
  output logic              valid_out,
  input  logic              ready_in,
  output rename_data_t      data_out,
  input  logic              free_valid,
  input  logic [PREG_W-1:0] free_preg
`ifdef RENAME_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  logic                valid_reg;
  rename_data_t        data_reg;
  rename_data_t        pkt_next;
  logic                fire_in;
  logic                fire_out;
  logic                alloc;
  logic                fl_push;
  logic [PREG_W-1:0]   fl_head;
  logic [FL_CNT_W-1:0] fl_count;
  logic [PREG_W-1:0]   rat_map [ARCH_REGS];

  // Stalls on an empty free list even for instructions without a destination.
  assign ready_out = (!valid_reg || ready_in) && (fl_count != '0);
  assign fire_in   = valid_in && ready_out;
  assign fire_out  = valid_reg && ready_in;
  assign alloc     = fire_in && data_in.reg_write && (data_in.rd != '0);
  assign fl_push   = free_valid && (free_preg != '0);

  for (genvar gi = 0; gi < ARCH_REGS; gi++) begin : g_rat
    if (gi == 0) begin : g_zero
      assign rat_map[gi] = '0;
    end else begin : g_map
      logic [PREG_W-1:0] map_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          map_reg <= PREG_W'(gi);
        end else if (alloc && (data_in.rd == AREG_W'(gi))) begin
          map_reg <= fl_head;
        end
      end
      assign rat_map[gi] = map_reg;
    end
  end

  rename_stage_free_list u_free_list (
    .clk       (clk),
    .reset     (reset),
    .pop       (alloc),
    .push      (fl_push),
    .push_preg (free_preg),
    .head_preg (fl_head),
    .count     (fl_count)
  );

  always_comb begin
    pkt_next           = '0;
    pkt_next.pc        = data_in.pc;
    pkt_next.rs1       = data_in.rs1;
    pkt_next.rs2       = data_in.rs2;
    pkt_next.rd        = data_in.rd;
    pkt_next.reg_write = data_in.reg_write;
    pkt_next.prs1      = rat_map[data_in.rs1];
    pkt_next.prs2      = rat_map[data_in.rs2];
    if (alloc) begin
      pkt_next.prd     = fl_head;
      pkt_next.old_prd = rat_map[data_in.rd];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (fire_in) begin
      valid_reg <= 1'b1;
      data_reg  <= pkt_next;
    end else if (fire_out) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid_out = valid_reg;
  assign data_out  = data_reg;

`ifdef RENAME_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if (valid_in && !ready_out && (fl_count == '0) && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign stall_cycles = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_rename_stage.sv
// Directed + randomized bench for rename_stage against a queue/array reference model.
module tb_rename_stage;
  import rename_stage_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_in;
  logic              ready_out;
  decode_data_t      din;
  logic              valid_out;
  logic              ready_in;
  rename_data_t      data_out;
  logic              free_valid;
  logic [PREG_W-1:0] free_preg;
`ifdef RENAME_STALL_CNT_EN
  logic [31:0]       stall_cycles;
`endif

  rename_stage dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .data_in    (din),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .data_out   (data_out),
    .free_valid (free_valid),
    .free_preg  (free_preg)
`ifdef RENAME_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural map as an int array, free list as a queue.
  int           m_rat [ARCH_REGS];
  int           m_fl [$];
  bit           m_valid;
  rename_data_t m_data;
  longint       m_stall;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ARCH_REGS; i++) m_rat[i] = i;
    m_fl.delete();
    for (int p = ARCH_REGS; p < PHYS_REGS; p++) m_fl.push_back(p);
    m_valid = 1'b0;
    m_data  = '0;
    m_stall = 0;
  endtask

  task automatic set_in(input bit v, input bit rdy, input int rs1, input int rs2,
                        input int rd, input bit rw, input bit fv, input int fp);
    valid_in      = v;
    ready_in      = rdy;
    din.pc        = $urandom;
    din.rs1       = AREG_W'(rs1);
    din.rs2       = AREG_W'(rs2);
    din.rd        = AREG_W'(rd);
    din.reg_write = rw;
    free_valid    = fv;
    free_preg     = PREG_W'(fp);
  endtask

  // One clock: check ready_out, advance the model, cross the edge, check outputs.
  task automatic step();
    bit           exp_ready;
    rename_data_t pkt;
    #1;
    exp_ready = (!m_valid || ready_in) && (m_fl.size() != 0);
    check("ready_out", ready_out, exp_ready);
    if (valid_in && !exp_ready && m_fl.size() == 0 && m_stall != 64'hFFFF_FFFF) m_stall++;
    if (valid_in && exp_ready) begin
      pkt           = '0;
      pkt.pc        = din.pc;
      pkt.rs1       = din.rs1;
      pkt.rs2       = din.rs2;
      pkt.rd        = din.rd;
      pkt.reg_write = din.reg_write;
      pkt.prs1      = PREG_W'(m_rat[din.rs1]);
      pkt.prs2      = PREG_W'(m_rat[din.rs2]);
      if (din.reg_write && din.rd != 0) begin
        pkt.prd     = PREG_W'(m_fl.pop_front());
        pkt.old_prd = PREG_W'(m_rat[din.rd]);
        m_rat[din.rd] = pkt.prd;
      end
      m_valid = 1'b1;
      m_data  = pkt;
    end else if (m_valid && ready_in) begin
      m_valid = 1'b0;
    end
    if (free_valid && free_preg != 0) m_fl.push_back(free_preg);
    @(posedge clk);
    #1;
    check("valid_out", valid_out, m_valid);
    check("data_out", data_out, m_data);
    check("fl_count", dut.fl_count, m_fl.size());
`ifdef RENAME_STALL_CNT_EN
    check("stall_cycles", stall_cycles, m_stall);
`endif
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 1, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", valid_out, 1'b0);
    check("reset_data", data_out, '0);
    check("reset_count", dut.fl_count, FL_DEPTH);
    reset = 1'b0;

    // Single ADD x5 = x1 + x2
    set_in(1, 1, 1, 2, 5, 1, 0, 0);
    step();
    $display("add rd=5: prs1=%0d prs2=%0d prd=%0d old_prd=%0d", data_out.prs1, data_out.prs2, data_out.prd, data_out.old_prd);
    check("t1_prs1", data_out.prs1, 1);
    check("t1_prs2", data_out.prs2, 2);
    check("t1_prd", data_out.prd, 32);
    check("t1_old_prd", data_out.old_prd, 5);

    // Dependent ADD x6 = x5 + x3 sees the new mapping of x5
    set_in(1, 1, 5, 3, 6, 1, 0, 0);
    step();
    $display("add rd=6 rs1=5: prs1=%0d prd=%0d", data_out.prs1, data_out.prd);
    check("t2_prs1", data_out.prs1, 32);
    check("t2_prd", data_out.prd, 33);

    // No-destination cases
    set_in(1, 1, 6, 5, 0, 1, 0, 0);
    step();
    $display("rd=0: prd=%0d old_prd=%0d", data_out.prd, data_out.old_prd);
    check("t3_rd0_prd", data_out.prd, 0);
    check("t3_rd0_old", data_out.old_prd, 0);
    set_in(1, 1, 6, 5, 7, 0, 0, 0);
    step();
    $display("reg_write=0: prd=%0d count=%0d", data_out.prd, dut.fl_count);
    check("t3_nowr_prd", data_out.prd, 0);
    check("t3_count", dut.fl_count, 94);

    // Downstream back-pressure for 3 cycles
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 1, 1, 9, 1, 0, 0);
      step();
      $display("stall cycle %0d: valid_out=%0d count=%0d", i, valid_out, dut.fl_count);
      check("bp_ready", ready_out, 1'b0);
      check("bp_count", dut.fl_count, 94);
      check("bp_rat9", dut.g_rat[9].g_map.map_reg, 9);
    end

    // Drain the free list with allocating instructions
    for (int i = 0; i < FL_DEPTH + 4 && m_fl.size() > 0; i++) begin
      set_in(1, 1, $urandom_range(0, 31), $urandom_range(0, 31), 1 + (i % 31), 1, 0, 0);
      step();
    end
    $display("drained: count=%0d", dut.fl_count);
    check("drain_count", dut.fl_count, 0);

    // Empty: stalled even with a same-cycle push of 40
    set_in(1, 1, 2, 3, 12, 1, 1, 40);
    #1;
    check("empty_ready", ready_out, 1'b0);
    step();
    set_in(1, 1, 2, 3, 12, 1, 0, 0);
    step();
    $display("refill: prd=%0d", data_out.prd);
    check("refill_prd", data_out.prd, 40);

    // Count==1 with simultaneous pop and push, then the pushed tag comes back
    set_in(0, 1, 0, 0, 0, 0, 1, 50);
    step();
    set_in(1, 1, 4, 4, 13, 1, 1, 10);
    step();
    $display("pop+push: prd=%0d count=%0d", data_out.prd, dut.fl_count);
    check("pp_prd", data_out.prd, 50);
    check("pp_count", dut.fl_count, 1);
    set_in(1, 1, 13, 4, 14, 1, 0, 0);
    step();
    $display("after wrap: prd=%0d prs1=%0d", data_out.prd, data_out.prs1);
    check("wrap_prd", data_out.prd, 10);
    check("wrap_prs1", data_out.prs1, 50);

    // Randomized traffic with frees
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 3) != 0,
             (m_fl.size() < FL_DEPTH) && ($urandom_range(0, 2) == 0),
             $urandom_range(0, PHYS_REGS - 1));
      step();
      if (i % 100 == 0) $display("random %0d: valid_out=%0d prd=%0d count=%0d", i, valid_out, data_out.prd, dut.fl_count);
    end

    // Reset mid-operation takes effect immediately
    set_in(1, 1, 3, 3, 3, 1, 0, 0);
    reset = 1'b1;
    #1;
    model_reset();
    $display("mid reset: valid_out=%0d count=%0d", valid_out, dut.fl_count);
    check("mreset_valid", valid_out, 1'b0);
    check("mreset_data", data_out, '0);
    check("mreset_count", dut.fl_count, FL_DEPTH);
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_in(1, 1, 3, 7, 3, 1, 0, 0);
    step();
    $display("post reset add: prs1=%0d prd=%0d old_prd=%0d", data_out.prs1, data_out.prd, data_out.old_prd);
    check("pr_prs1", data_out.prs1, 3);
    check("pr_prd", data_out.prd, 32);
    check("pr_old_prd", data_out.old_prd, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
